// File: rtl/pc_ir_unit.sv
// pc_ir_unit: program counter, instruction memory and instruction register for a multicycle datapath.
module pc_ir_unit #(
    parameter int WIDTH = 16,
    parameter int IM_AW = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             PCWrite,
    input  logic             PCWriteCondEq,
    input  logic             PCWriteCondNeq,
    input  logic             PCSrc,
    input  logic             IMRead,
    input  logic             IRWrite,
    input  logic             IMWrite,
    input  logic [IM_AW-1:0] IMAddr,
    input  logic [WIDTH-1:0] IMData,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic             Zero,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCOld,
    output logic [WIDTH-1:0] IR,
    output logic [3:0]       Op,
    output logic [3:0]       Rs,
    output logic [3:0]       Rt,
    output logic [3:0]       Rd,
    output logic [WIDTH-1:0] InstrCount
);
    logic [WIDTH-1:0] im [2**IM_AW];
    logic [WIDTH-1:0] im_word;
    logic             pc_en;
    logic             fetch;

    assign im_word = im[PC[IM_AW-1:0]];
    assign pc_en   = PCWrite | (PCWriteCondEq & Zero) | (PCWriteCondNeq & ~Zero);
    assign fetch   = IMRead & IRWrite;
    assign Op      = IR[15:12];
    assign Rs      = IR[11:8];
    assign Rt      = IR[7:4];
    assign Rd      = IR[3:0];

    // Memory is not reset so a program can be loaded while Reset is held.
    always_ff @(posedge Clk) begin
        if (IMWrite) im[IMAddr] <= IMData;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC         <= '0;
            PCOld      <= '0;
            IR         <= '0;
            InstrCount <= '0;
        end else begin
            if (pc_en) PC <= PCSrc ? ALUOut : ALUResult;
            if (fetch) begin
                IR    <= im_word;
                PCOld <= PC;
                if (InstrCount != '1) InstrCount <= InstrCount + 1'b1;
            end
        end
    end
endmodule
